card_session_ctrl: RTL and testbench
====================================

// Module: card_session_ctrl
// PURPOSE
// - Session sequencer for the card-payment display path: turns card/key inputs into the
//   state, cost, left, press and cancel_flag values the 8-digit display block renders.
// - Owns the stored card balance, the HELLO/SETTLE dwell timers and purchase accounting.
// - All money values are 8-bit half-yuan units (bit0 = 0.5); max 127.5.
// PARAMETERS
// - HELLO_TICKS   2000   clk_N cycles spent in HELLO before CONSUME (>=1)
// - SETTLE_TICKS  4000   minimum clk_N cycles spent in SETTLE (>=1)
// - INIT_BALANCE  8'd200 balance loaded at reset (100.0)
// PORTS
// - clk_N        in   1  display/scan clock; all logic on posedge
// - rst_n        in   1  asynchronous, active-low reset
// - card_in      in   1  card present (level, debounced)
// - key_add      in   1  add one item of price_sel (level, debounced)
// - price_sel    in   2  item select: 0=1.0, 1=2.5, 2=5.0, 3=10.0
// - key_ok       in   1  confirm purchase (level, debounced)
// - key_cancel   in   1  cancel purchase (level, debounced)
// - state        out  2  00 IDLE, 01 HELLO, 10 CONSUME, 11 SETTLE
// - cost         out  8  running purchase total
// - left         out  8  balance remaining after cost
// - press        out  1  high throughout SETTLE entered by confirm
// - cancel_flag  out  1  high throughout SETTLE entered by cancel
// - deny         out  1  one-cycle pulse: add rejected (insufficient balance)
// BEHAVIOUR
// - Reset: state=00, cost=0, left=0, press=0, cancel_flag=0, deny=0, timer=0, bal=INIT_BALANCE.
// - Keys: registered copy each cycle; action on rising edge (key & ~key_q) only, one per press.
//   All outputs registered; an edge seen at clock k is visible after clock k.
// - IDLE: cost=left=0. card_in=1 -> HELLO, timer=0, left<=bal.
// - HELLO: timer counts; at timer==HELLO_TICKS-1 -> CONSUME, timer=0. card_in=0 -> IDLE, left=0.
// - CONSUME: add edge, p=price(price_sel): if p<=left {cost+=p; left-=p} else deny=1, no change.
//   Invariant cost+left==bal holds; no overflow possible.
// - CONSUME exits (priority high->low): card_in=0 or cancel edge -> SETTLE, cancel_flag=1, bal
//   unchanged; ok edge -> SETTLE, press=1, bal<=left. Same-cycle add with either exit: add ignored.
// - cost=0 at ok: confirm still legal (press=1, bal unchanged).
// - SETTLE: cost/left frozen; timer saturates at SETTLE_TICKS-1; keys ignored. Leaves when
//   timer saturated AND card_in=0 -> IDLE: cost=0, left=0, press=0, cancel_flag=0.
//   Card held past timeout: stay in SETTLE (no new session without re-insert).
// - bal persists across sessions; bal=0 at insert: session runs, every add denied.
// - press and cancel_flag never both 1; both 0 outside SETTLE.
// - rst_n low mid-session: immediate return to reset values, pending purchase discarded.
// STRUCTURE
// - Shared package card_pkg: state codes ST_IDLE/ST_HELLO/ST_CONSUME/ST_SETTLE (encodings
//   fixed, consumed by display), PRICE_TABLE[4] = {2,5,10,20}, money width MONEY_W=8.
// - One sub-module: key_edge (N-bit register + rising-edge detect), instantiated for
//   {key_add,key_ok,key_cancel}. Single shared dwell timer, width from max(HELLO,SETTLE).
// TESTING (bench with HELLO_TICKS=4, SETTLE_TICKS=6)
// - Reset, card_in=1 -> state 01 for 4 cycles, then 10 with cost=0,left=200.
// - sel=3 add x3, sel=1 add x1 -> cost=65,left=135; ok -> state 11,press=1; card out after 6 -> 00; next insert left=135.
// - bal=135, sel=3 add x6 then sel=3 add -> 7th add deny pulse 1 cycle, cost=120,left=15.
// - cost=20 then key_ok and key_cancel same edge -> cancel_flag=1,press=0; next session left=bal unchanged.
// - Card removed in CONSUME with cost=10 -> SETTLE, cancel_flag=1; card held in SETTLE 20 cycles -> stays 11.
// - rst_n low during CONSUME (cost=30) -> all outputs 0 asynchronously, bal back to 200.

Source files
------------

// File: rtl/card_pkg.sv
// card_pkg: state codes, money width and item price table shared by the session controller
package card_pkg;
    localparam int MONEY_W = 8;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_HELLO   = 2'b01,
        ST_CONSUME = 2'b10,
        ST_SETTLE  = 2'b11
    } state_t;
    localparam logic [MONEY_W-1:0] PRICE_TABLE [4] = '{8'd2, 8'd5, 8'd10, 8'd20};
endpackage

// File: rtl/card_session_ctrl_if.sv
// card_session_ctrl_if: card/key inputs and display-facing session outputs
interface card_session_ctrl_if;
    import card_pkg::*;
    logic               card_in;
    logic               key_add;
    logic [1:0]         price_sel;
    logic               key_ok;
    logic               key_cancel;
    logic [1:0]         state;
    logic [MONEY_W-1:0] cost;
    logic [MONEY_W-1:0] left;
    logic               press;
    logic               cancel_flag;
    logic               deny;
    modport master (
        output card_in, key_add, price_sel, key_ok, key_cancel,
        input  state, cost, left, press, cancel_flag, deny
    );
    modport slave (
        input  card_in, key_add, price_sel, key_ok, key_cancel,
        output state, cost, left, press, cancel_flag, deny
    );
endinterface

// File: rtl/card_session_ctrl_key_edge.sv
// key_edge: registers N key levels and flags the cycle each one rises
module key_edge #(
    parameter int N = 1
) (
    input  logic         clk_N,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] rise
);
    logic [N-1:0] q;
    // last cycle's key levels
    always_ff @(posedge clk_N or negedge rst_n)
        if (!rst_n) q <= '0;
        else        q <= d;
    assign rise = d & ~q;
endmodule

// File: rtl/card_session_ctrl.sv
// card_session_ctrl: card session sequencer owning balance, dwell timer and purchase totals
module card_session_ctrl
    import card_pkg::*;
#(
    parameter int                 HELLO_TICKS  = 2000,
    parameter int                 SETTLE_TICKS = 4000,
    parameter logic [MONEY_W-1:0] INIT_BALANCE = 8'd200
) (
    input logic               clk_N,
    input logic               rst_n,
    card_session_ctrl_if.slave bus
);
    localparam int T_MAX = (HELLO_TICKS > SETTLE_TICKS) ? HELLO_TICKS : SETTLE_TICKS;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] HELLO_LAST  = TW'(HELLO_TICKS - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_TICKS - 1);

    state_t             state, state_n;
    logic [TW-1:0]      timer, timer_n;
    logic [MONEY_W-1:0] cost, cost_n, left, left_n, bal, bal_n, price;
    logic               press, press_n, cancel_flag, cancel_n, deny, deny_n;
    logic               add_e, ok_e, cancel_e;

    key_edge #(.N(3)) u_keys (
        .clk_N (clk_N),
        .rst_n (rst_n),
        .d     ({bus.key_add, bus.key_ok, bus.key_cancel}),
        .rise  ({add_e, ok_e, cancel_e})
    );

    assign price = PRICE_TABLE[bus.price_sel];

    // session registers; reset discards any pending purchase and restores the opening balance
    always_ff @(posedge clk_N or negedge rst_n)
        if (!rst_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            cost        <= '0;
            left        <= '0;
            bal         <= INIT_BALANCE;
            press       <= 1'b0;
            cancel_flag <= 1'b0;
            deny        <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            cost        <= cost_n;
            left        <= left_n;
            bal         <= bal_n;
            press       <= press_n;
            cancel_flag <= cancel_n;
            deny        <= deny_n;
        end

    // next session state; card removal or cancel outrank confirm, and any exit swallows a same-cycle add
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        cost_n   = cost;
        left_n   = left;
        bal_n    = bal;
        press_n  = press;
        cancel_n = cancel_flag;
        deny_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                cost_n = '0;
                left_n = '0;
                if (bus.card_in) begin
                    state_n = ST_HELLO;
                    timer_n = '0;
                    left_n  = bal;
                end
            end
            ST_HELLO: begin
                timer_n = timer + 1'b1;
                if (!bus.card_in) begin
                    state_n = ST_IDLE;
                    timer_n = '0;
                    left_n  = '0;
                end else if (timer == HELLO_LAST) begin
                    state_n = ST_CONSUME;
                    timer_n = '0;
                end
            end
            ST_CONSUME: begin
                if (!bus.card_in || cancel_e) begin
                    state_n  = ST_SETTLE;
                    timer_n  = '0;
                    cancel_n = 1'b1;
                end else if (ok_e) begin
                    state_n = ST_SETTLE;
                    timer_n = '0;
                    press_n = 1'b1;
                    bal_n   = left;
                end else if (add_e) begin
                    if (price <= left) begin
                        cost_n = cost + price;
                        left_n = left - price;
                    end else
                        deny_n = 1'b1;
                end
            end
            default: begin
                timer_n = (timer == SETTLE_LAST) ? timer : timer + 1'b1;
                if (timer == SETTLE_LAST && !bus.card_in) begin
                    state_n  = ST_IDLE;
                    timer_n  = '0;
                    cost_n   = '0;
                    left_n   = '0;
                    press_n  = 1'b0;
                    cancel_n = 1'b0;
                end
            end
        endcase
    end

    assign bus.state       = state;
    assign bus.cost        = cost;
    assign bus.left        = left;
    assign bus.press       = press;
    assign bus.cancel_flag = cancel_flag;
    assign bus.deny        = deny;
endmodule

// File: tb/tb_card_session_ctrl.sv
// tb_card_session_ctrl: scenario tasks checked against a purchase/balance model of the session rules
module tb_card_session_ctrl;
    localparam int HT = 4;
    localparam int ST = 6;

    logic clk_N = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_N = ~clk_N;

    card_session_ctrl_if bus();

    card_session_ctrl #(
        .HELLO_TICKS  (HT),
        .SETTLE_TICKS (ST),
        .INIT_BALANCE (8'd200)
    ) dut (
        .clk_N (clk_N),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] m_bal, m_cost, m_left;

    function automatic logic [7:0] price_of(input int sel);
        case (sel)
            0:       return 8'd2;
            1:       return 8'd5;
            2:       return 8'd10;
            default: return 8'd20;
        endcase
    endfunction

    task automatic step();
        @(posedge clk_N);
        #1;
    endtask

    task automatic idle_inputs();
        bus.card_in = 1'b0; bus.key_add = 1'b0; bus.key_ok = 1'b0;
        bus.key_cancel = 1'b0; bus.price_sel = 2'd0;
    endtask

    task automatic insert_session();
        bus.card_in = 1'b1;
        for (int i = 0; i < HT; i++) begin
            step();
            tests++; if (bus.state !== 2'b01) begin fails++; $display("FAIL hello_state[%0d]: got %0d expected 1", i, bus.state); end
        end
        step();
        m_cost = 8'd0; m_left = m_bal;
        tests++; if (bus.state !== 2'b10) begin fails++; $display("FAIL consume_state: got %0d expected 2", bus.state); end
        tests++; if (bus.cost !== 8'd0 || bus.left !== m_left) begin fails++; $display("FAIL consume_entry: got cost=%0d left=%0d expected cost=0 left=%0d", bus.cost, bus.left, m_left); end
    endtask

    task automatic add_item(input int sel);
        logic exp_deny;
        bus.price_sel = 2'(sel); bus.key_add = 1'b1;
        step();
        exp_deny = price_of(sel) > m_left;
        if (!exp_deny) begin m_cost = m_cost + price_of(sel); m_left = m_left - price_of(sel); end
        tests++; if (bus.deny !== exp_deny || bus.cost !== m_cost || bus.left !== m_left) begin fails++; $display("FAIL add sel=%0d: got deny=%0d cost=%0d left=%0d expected deny=%0d cost=%0d left=%0d", sel, bus.deny, bus.cost, bus.left, exp_deny, m_cost, m_left); end
        bus.key_add = 1'b0;
        step();
        tests++; if (bus.deny !== 1'b0) begin fails++; $display("FAIL deny_pulse_width: got %0d expected 0", bus.deny); end
    endtask

    task automatic wait_settle_end();
        int n = 0;
        bus.card_in = 1'b0; bus.key_ok = 1'b0; bus.key_cancel = 1'b0; bus.key_add = 1'b0;
        do begin step(); n++; end while (bus.state === 2'b11 && n < 50);
        tests++; if (n != ST || bus.state !== 2'b00) begin fails++; $display("FAIL settle_dwell: got %0d cycles state=%0d expected %0d cycles state=0", n, bus.state, ST); end
        tests++; if (bus.cost !== 8'd0 || bus.left !== 8'd0 || bus.press !== 1'b0 || bus.cancel_flag !== 1'b0) begin fails++; $display("FAIL idle_clear: got cost=%0d left=%0d press=%0d cancel=%0d expected all 0", bus.cost, bus.left, bus.press, bus.cancel_flag); end
    endtask

    task automatic exit_session(input int how, input logic with_add);
        logic exp_press;
        exp_press = (how == 0);
        if (how == 0) bus.key_ok = 1'b1;
        else if (how == 1) bus.key_cancel = 1'b1;
        else bus.card_in = 1'b0;
        if (with_add) begin bus.price_sel = 2'($urandom_range(0, 3)); bus.key_add = 1'b1; end
        step();
        if (exp_press) m_bal = m_left;
        tests++; if (bus.state !== 2'b11 || bus.press !== exp_press || bus.cancel_flag !== !exp_press) begin fails++; $display("FAIL exit how=%0d: got state=%0d press=%0d cancel=%0d expected state=3 press=%0d cancel=%0d", how, bus.state, bus.press, bus.cancel_flag, exp_press, !exp_press); end
        tests++; if (bus.cost !== m_cost || bus.left !== m_left) begin fails++; $display("FAIL settle_frozen: got cost=%0d left=%0d expected cost=%0d left=%0d", bus.cost, bus.left, m_cost, m_left); end
        wait_settle_end();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step(); step();
        tests++; if (bus.state !== 2'b00 || bus.cost !== 8'd0 || bus.left !== 8'd0 || bus.press !== 1'b0 || bus.cancel_flag !== 1'b0 || bus.deny !== 1'b0) begin fails++; $display("FAIL reset: got state=%0d cost=%0d left=%0d press=%0d cancel=%0d deny=%0d expected all 0", bus.state, bus.cost, bus.left, bus.press, bus.cancel_flag, bus.deny); end
        rst_n = 1'b1;
        m_bal = 8'd200;
        step();
    endtask

    task automatic test_purchase();
        insert_session();
        for (int i = 0; i < 3; i++) add_item(3);
        add_item(1);
        tests++; if (bus.cost !== 8'd65 || bus.left !== 8'd135) begin fails++; $display("FAIL purchase_total: got cost=%0d left=%0d expected 65/135", bus.cost, bus.left); end
        exit_session(0, 1'b0);
        tests++; if (m_bal !== 8'd135) begin fails++; $display("FAIL model_balance: got %0d expected 135", m_bal); end
    endtask

    task automatic test_deny();
        insert_session();
        for (int i = 0; i < 7; i++) add_item(3);
        tests++; if (bus.cost !== 8'd120 || bus.left !== 8'd15) begin fails++; $display("FAIL deny_total: got cost=%0d left=%0d expected 120/15", bus.cost, bus.left); end
        exit_session(1, 1'b0);
    endtask

    task automatic test_ok_and_cancel();
        insert_session();
        add_item(3);
        bus.key_ok = 1'b1;
        exit_session(1, 1'b0);
    endtask

    task automatic test_card_hold();
        int n = 0;
        insert_session();
        add_item(2);
        bus.card_in = 1'b0;
        step();
        tests++; if (bus.state !== 2'b11 || bus.cancel_flag !== 1'b1 || bus.press !== 1'b0) begin fails++; $display("FAIL card_pull: got state=%0d cancel=%0d press=%0d expected 3/1/0", bus.state, bus.cancel_flag, bus.press); end
        bus.card_in = 1'b1;
        for (int i = 0; i < 20; i++) begin step(); if (bus.state === 2'b11) n++; end
        tests++; if (n != 20) begin fails++; $display("FAIL card_hold: got %0d settle cycles expected 20", n); end
        bus.card_in = 1'b0;
        step();
        tests++; if (bus.state !== 2'b00 || bus.cancel_flag !== 1'b0) begin fails++; $display("FAIL hold_release: got state=%0d cancel=%0d expected 0/0", bus.state, bus.cancel_flag); end
    endtask

    task automatic test_zero_cost_ok();
        insert_session();
        exit_session(0, 1'b0);
    endtask

    task automatic test_random_sessions();
        for (int s = 0; s < 6; s++) begin
            insert_session();
            for (int k = $urandom_range(1, 8); k > 0; k--) add_item($urandom_range(0, 3));
            exit_session($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_async_reset();
        insert_session();
        add_item(3);
        add_item(2);
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.state !== 2'b00 || bus.cost !== 8'd0 || bus.left !== 8'd0 || bus.press !== 1'b0 || bus.cancel_flag !== 1'b0 || bus.deny !== 1'b0) begin fails++; $display("FAIL async_reset: got state=%0d cost=%0d left=%0d press=%0d cancel=%0d deny=%0d expected all 0", bus.state, bus.cost, bus.left, bus.press, bus.cancel_flag, bus.deny); end
        idle_inputs();
        step();
        rst_n = 1'b1;
        m_bal = 8'd200;
        step();
        insert_session();
        exit_session(1, 1'b0);
    endtask

    task automatic test_zero_balance();
        insert_session();
        for (int i = 0; i < 10; i++) add_item(3);
        exit_session(0, 1'b0);
        tests++; if (m_bal !== 8'd0) begin fails++; $display("FAIL drain_balance: got %0d expected 0", m_bal); end
        insert_session();
        add_item(0);
        add_item(2);
        exit_session(2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_purchase();
        test_deny();
        test_ok_and_cancel();
        test_card_hold();
        test_zero_cost_ok();
        test_random_sessions();
        test_async_reset();
        test_zero_balance();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
